alg_amba_vip_base_vldrdy_sink: RTL
==================================

ALG_AMBA_VIP_BASE_VLDRDY_SINK -- requirements
Module: alg_amba_vip_base_vldrdy_sink

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, payload width (1..1024).
REQ-002 SHALL have parameter BP_SEED, default 16'hACE1, nonzero backpressure LFSR reset value.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset; one clock, reset synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  upstream beat valid.
REQ-006 SHALL have port in_data  input  DATA_WIDTH  upstream payload.
REQ-007 SHALL have port in_ready  output  1  registered ready to upstream.
REQ-008 SHALL have port cfg_bp_mode  input  2  backpressure mode: 0 always, 1 never, 2 random, 3 periodic.
REQ-009 SHALL have port cfg_bp_thresh  input  8  random-mode threshold.
REQ-010 SHALL have port cfg_period  input  8  periodic-mode period minus one.
REQ-011 SHALL have port clr  input  1  synchronous clear of counters and error.
REQ-012 SHALL have port rx_valid  output  1  one-cycle pulse per accepted beat.
REQ-013 SHALL have port rx_data  output  DATA_WIDTH  last accepted payload.
REQ-014 SHALL have port beat_cnt  output  32  accepted-beat count.
REQ-015 SHALL have port err_proto  output  1  sticky protocol-violation flag.

Function
REQ-016 Handshake: beat accepted in cycle where in_valid=1 and in_ready=1; no combinational path from in_valid/in_data to in_ready.
REQ-017 in_ready SHALL be a flop; value in cycle N+1 computed from mode state in cycle N.
REQ-018 Mode 0: in_ready=1 every cycle after reset release; mode 1: in_ready=0.
REQ-019 Mode 2: 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle in mode 2 only; next in_ready = (lfsr[7:0] >= cfg_bp_thresh); thresh 0 equals always ready.
REQ-020 Mode 3: 8-bit counter 0..cfg_period, wraps to 0; next in_ready=1 only when counter==cfg_period; cfg_period 0 equals always ready; counter forced to 0 when mode!=3.
REQ-021 Mode change takes effect on in_ready one cycle later; no accepted beat lost or duplicated across change.
REQ-022 Accepted beat: rx_valid=1 and rx_data=in_data in next cycle (latency 1); rx_data holds otherwise.
REQ-023 beat_cnt increments by 1 per accepted beat; saturates at 32'hFFFF_FFFF, no wrap.
REQ-024 clr: beat_cnt=0, err_proto=0 next cycle; clr with simultaneous handshake gives beat_cnt=0 (clr wins); rx_valid/rx_data unaffected by clr.
REQ-025 Protocol check: if in_valid=1 and in_ready=0 in cycle N, then cycle N+1 SHALL have in_valid=1 and in_data unchanged; otherwise err_proto set next cycle, sticky until clr or reset.
REQ-026 in_valid asserted while in_ready=0 SHALL not itself be an error; in_data value with in_valid=0 ignored.

Reset
REQ-027 During rstn=0: in_ready=0, rx_valid=0, rx_data=0, beat_cnt=0, err_proto=0, lfsr=BP_SEED, period counter=0.
REQ-028 First cycle after release: in_ready=0; in mode 0 in_ready=1 from second cycle.
REQ-029 Reset mid-transfer SHALL drop pending beat; no count, no rx_valid, no error from the interrupted beat.

Configuration
REQ-030 Macro ALG_VLDRDY_SINK_PROTO_CHK_EN: defined -> REQ-025 checker compiled in; undefined -> checker logic absent, err_proto tied 0; all other behaviour identical.

Verification
REQ-031 Mode 0, 8 back-to-back beats 0x01..0x08 -> 8 rx_valid pulses, rx_data 0x01..0x08 in order, beat_cnt=8, err_proto=0.
REQ-032 Mode 3, cfg_period=3, continuous valid -> in_ready high 1 cycle in 4; 5 beats accepted in 20 cycles, each held stable until accepted.
REQ-033 Mode 2, cfg_bp_thresh=0x80, 1000 beats with stable-hold source -> all 1000 received in order, beat_cnt=1000, in_ready duty roughly 50%.
REQ-034 Mode 1, in_valid=1 data 0xA5 then data 0x5A next cycle -> err_proto=1 following cycle (macro defined), stays 0 (macro undefined); clr -> err_proto=0.
REQ-035 beat_cnt preloaded near max via 2^32-1 beats (forced) plus one beat -> beat_cnt remains 32'hFFFF_FFFF; clr with same-cycle handshake -> beat_cnt=0.
REQ-036 rstn low for 1 cycle mid-stream in mode 0 -> all outputs to reset values, in_ready=0 one cycle after release, then 1.

Source files
------------

// File: rtl/alg_amba_vip_base_vldrdy_sink.sv
// alg_amba_vip_base_vldrdy_sink: valid/ready sink with configurable registered backpressure.
// Define ALG_VLDRDY_SINK_PROTO_CHK_EN to compile in the stable-hold protocol checker.
module alg_amba_vip_base_vldrdy_sink #(
    parameter int          DATA_WIDTH = 1,
    parameter logic [15:0] BP_SEED    = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic [1:0]            cfg_bp_mode,
    input  logic [7:0]            cfg_bp_thresh,
    input  logic [7:0]            cfg_period,
    input  logic                  clr,
    output logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic [31:0]           beat_cnt,
    output logic                  err_proto
);
    logic [15:0] lfsr;
    logic [7:0]  pcnt;
    logic        ready_nxt;
    logic        acc;

    assign acc = in_valid & in_ready;

    // ready is decided purely from mode state, never from the upstream inputs
    always_comb begin
        ready_nxt = cfg_bp_mode == 2'd0 ? 1'b1 :
                    cfg_bp_mode == 2'd1 ? 1'b0 :
                    cfg_bp_mode == 2'd2 ? (lfsr[7:0] >= cfg_bp_thresh) :
                                          (pcnt == cfg_period);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            in_ready <= 1'b0;
            lfsr     <= BP_SEED;
            pcnt     <= 8'd0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            beat_cnt <= 32'd0;
        end else begin
            in_ready <= ready_nxt;
            if (cfg_bp_mode == 2'd2)
                lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            pcnt     <= (cfg_bp_mode != 2'd3 || pcnt == cfg_period) ? 8'd0 : pcnt + 8'd1;
            rx_valid <= acc;
            if (acc)
                rx_data <= in_data;
            if (clr)
                beat_cnt <= 32'd0;
            else if (acc && beat_cnt != 32'hFFFF_FFFF)
                beat_cnt <= beat_cnt + 32'd1;
        end
    end

`ifdef ALG_VLDRDY_SINK_PROTO_CHK_EN
    logic                  pend;
    logic [DATA_WIDTH-1:0] pend_data;

    // a stalled beat must be presented again, unchanged, on the following cycle
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend      <= 1'b0;
            pend_data <= '0;
            err_proto <= 1'b0;
        end else begin
            pend      <= in_valid & ~in_ready;
            pend_data <= in_data;
            if (clr)
                err_proto <= 1'b0;
            else if (pend && (!in_valid || in_data != pend_data))
                err_proto <= 1'b1;
        end
    end
`else
    assign err_proto = 1'b0;
`endif
endmodule
